seg_readback_decoder: RTL and testbench

Reads the multiplexed 7-segment display bus (segment lines `C[7:1]`, active-low anodes `AN[3:0]`) and reconstructs the 16-bit hex word being shown. It is the receiving end of the display scan interface and is used for on-chip loopback checking of the display path. A digit value is accepted only after its (AN, C) pattern has held stable for a programmable number of cycles. Each completed four-digit frame yields one registered word plus an error flag.

---
 rtl/seg_readback_decoder.sv | 218 +++++++++++++++++++++
 tb/tb_seg_readback_decoder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_readback_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_readback_decoder
// Description : Receives a multiplexed 7-segment display scan and rebuilds
//               the 16-bit hex word being shown. Each (AN, C) pair must be
//               sampled unchanged on SETTLE_CYCLES consecutive edges before
//               its digit is accepted. Each completed four-digit frame gives
//               one registered word, a one-cycle word_valid pulse and a
//               frame error flag.
// Ports       : clk        - system clock, rising edge
//               reset      - synchronous active-high reset
//               C[7:1]     - segment lines, active-low (C[1]=a .. C[7]=g)
//               AN[3:0]    - digit enables, active-low
//               word       - last completed frame, nibble 0 = bits 3:0
//               word_valid - one-cycle pulse when word updates
//               frame_err  - set if any digit of that frame was illegal
//               err_count  - saturating count of frames with frame_err set
// Options     : SEG_READBACK_ERRCNT_EN - when defined, builds the error frame
//               counter; otherwise err_count is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_readback_decoder #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:1]  C,
  input  logic [3:0]  AN,
  output logic [15:0] word,
  output logic        word_valid,
  output logic        frame_err,
  output logic [7:0]  err_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DWELL = 2'd1;
  localparam logic [1:0] ST_HELD  = 2'd2;

  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

  logic [1:0]  state, state_nx;
  logic [7:0]  count, count_nx;
  logic [3:0]  prev_an;
  logic [7:1]  prev_c;
  logic [15:0] shadow, shadow_upd;
  logic [3:0]  captured, cap_upd;
  logic [3:0]  dig_err, err_upd;

  logic        an_valid;
  logic [1:0]  digit_idx;
  logic        same;
  logic [3:0]  seg_nib;
  logic        seg_err;
  logic        accept;
  logic        frame_done;

  // Exactly one anode low selects a digit; anything else is not a digit.
  always_comb begin
    an_valid  = 1'b1;
    digit_idx = 2'd0;
    case (AN)
      4'b0111: digit_idx = 2'd0;
      4'b1011: digit_idx = 2'd1;
      4'b1101: digit_idx = 2'd2;
      4'b1110: digit_idx = 2'd3;
      default: an_valid  = 1'b0;
    endcase
  end

  // Segment patterns listed g..a (MSB = C[7]); unknown glyphs decode to 0.
  always_comb begin
    seg_err = 1'b0;
    seg_nib = 4'h0;
    case (C)
      7'b1000000: seg_nib = 4'h0;
      7'b1111001: seg_nib = 4'h1;
      7'b0100100: seg_nib = 4'h2;
      7'b0110000: seg_nib = 4'h3;
      7'b0011001: seg_nib = 4'h4;
      7'b0010010: seg_nib = 4'h5;
      7'b0000010: seg_nib = 4'h6;
      7'b1111000: seg_nib = 4'h7;
      7'b0000000: seg_nib = 4'h8;
      7'b0010000: seg_nib = 4'h9;
      7'b0001000: seg_nib = 4'hA;
      7'b0000011: seg_nib = 4'hB;
      7'b1000110: seg_nib = 4'hC;
      7'b0100001: seg_nib = 4'hD;
      7'b0000110: seg_nib = 4'hE;
      7'b0001110: seg_nib = 4'hF;
      default:    seg_err = 1'b1;
    endcase
  end

  assign same = (AN == prev_an) && (C == prev_c);

  // Dwell tracker. A fresh valid pair starts a dwell at count 1; when that
  // already meets SETTLE (SETTLE_CYCLES = 1) the digit is accepted at once.
  always_comb begin
    state_nx = state;
    count_nx = count;
    accept   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (an_valid) begin
          count_nx = 8'd1;
          if (SETTLE <= 8'd1) begin
            accept   = 1'b1;
            state_nx = ST_HELD;
          end else begin
            state_nx = ST_DWELL;
          end
        end
      end
      ST_DWELL: begin
        if (!an_valid) begin
          state_nx = ST_IDLE;
          count_nx = 8'd0;
        end else if (same) begin
          // count < SETTLE here, so the increment cannot wrap
          if (count + 8'd1 >= SETTLE) begin
            count_nx = SETTLE;
            accept   = 1'b1;
            state_nx = ST_HELD;
          end else begin
            count_nx = count + 8'd1;
          end
        end else begin
          count_nx = 8'd1;
          if (SETTLE <= 8'd1) begin
            accept   = 1'b1;
            state_nx = ST_HELD;
          end
        end
      end
      ST_HELD: begin
        // Count stays saturated while the pair holds: one accept per dwell.
        if (!an_valid) begin
          state_nx = ST_IDLE;
          count_nx = 8'd0;
        end else if (!same) begin
          count_nx = 8'd1;
          if (SETTLE <= 8'd1) begin
            accept   = 1'b1;
            state_nx = ST_HELD;
          end else begin
            state_nx = ST_DWELL;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
        count_nx = 8'd0;
      end
    endcase
  end

  // Shadow image including this edge's accept, so a frame can complete on
  // the same edge as its final digit.
  always_comb begin
    shadow_upd = shadow;
    err_upd    = dig_err;
    cap_upd    = captured;
    if (accept) begin
      shadow_upd[{digit_idx, 2'b00} +: 4] = seg_nib;
      err_upd[digit_idx]                  = seg_err;
      cap_upd[digit_idx]                  = 1'b1;
    end
  end

  assign frame_done = accept && (cap_upd == 4'hF);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      count      <= 8'd0;
      prev_an    <= 4'd0;
      prev_c     <= 7'd0;
      shadow     <= 16'd0;
      captured   <= 4'd0;
      dig_err    <= 4'd0;
      word       <= 16'd0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      prev_an    <= AN;
      prev_c     <= C;
      shadow     <= shadow_upd;
      word_valid <= frame_done;
      if (frame_done) begin
        word      <= shadow_upd;
        frame_err <= |err_upd;
        captured  <= 4'd0;
        dig_err   <= 4'd0;
      end else begin
        captured  <= cap_upd;
        dig_err   <= err_upd;
      end
    end
  end

`ifdef SEG_READBACK_ERRCNT_EN
  // Counts on the completing edge so err_count moves together with frame_err.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= 8'd0;
    end else if (frame_done && (|err_upd) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  assign err_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg_readback_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_readback_decoder
// Description : Self-checking bench for seg_readback_decoder: reset check,
//               table of single-glyph frames, hand-written scan sequences,
//               and randomized scan traffic against a run-length model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_readback_decoder;

  localparam int SETTLE = 4;
`ifdef SEG_READBACK_ERRCNT_EN
  localparam int ERRCNT_ON = 1;
`else
  localparam int ERRCNT_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:1]  c_in = 7'h7F;
  logic [3:0]  an_in = 4'hF;
  logic [15:0] word;
  logic        word_valid;
  logic        frame_err;
  logic [7:0]  err_count;

  seg_readback_decoder #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk       (clk),
    .reset     (reset),
    .C         (c_in),
    .AN        (an_in),
    .word      (word),
    .word_valid(word_valid),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  int pulses = 0;
  int pulse_at[$];

  // ---------------- reference model (run-length view of the bus) ----------
  int          run;
  logic [10:0] last_pair;
  bit          last_ok;
  logic [3:0]  m_sh[4];
  bit          m_er[4];
  logic [3:0]  m_cap;
  logic [15:0] e_word;
  bit          e_wv, e_fe;
  int          e_cnt;

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0:  return 7'b1000000;  1:  return 7'b1111001;
      2:  return 7'b0100100;  3:  return 7'b0110000;
      4:  return 7'b0011001;  5:  return 7'b0010010;
      6:  return 7'b0000010;  7:  return 7'b1111000;
      8:  return 7'b0000000;  9:  return 7'b0010000;
      10: return 7'b0001000;  11: return 7'b0000011;
      12: return 7'b1000110;  13: return 7'b0100001;
      14: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [3:0] an_of(input int d);
    return ~(4'b1000 >> d);
  endfunction

  function automatic int digit_of(input logic [3:0] an);
    for (int d = 0; d < 4; d++) if (an == an_of(d)) return d;
    return -1;
  endfunction

  task automatic model_reset();
    run = 0; last_pair = '0; last_ok = 0; m_cap = 0;
    for (int i = 0; i < 4; i++) begin m_sh[i] = 0; m_er[i] = 0; end
    e_word = 0; e_wv = 0; e_fe = 0; e_cnt = 0;
  endtask

  task automatic model_edge(input logic rst, input logic [3:0] an, input logic [6:0] c);
    int d;
    logic [3:0] nib;
    bit bad;
    e_wv = 0;
    if (rst) begin
      model_reset();
      return;
    end
    d = digit_of(an);
    if (d < 0) begin
      run = 0;
    end else begin
      if (last_ok && {an, c} == last_pair) begin
        if (run < 1000000) run++;
      end else begin
        run = 1;
      end
      if (run == SETTLE) begin
        nib = 0; bad = 1;
        for (int v = 0; v < 16; v++)
          if (seg_of(v) == c) begin nib = 4'(v); bad = 0; end
        m_sh[d] = nib; m_er[d] = bad; m_cap[d] = 1'b1;
        if (m_cap == 4'hF) begin
          e_word = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
          e_fe   = m_er[0] | m_er[1] | m_er[2] | m_er[3];
          e_wv   = 1;
          if (e_fe && ERRCNT_ON == 1 && e_cnt < 255) e_cnt++;
          m_cap = 0;
          for (int i = 0; i < 4; i++) m_er[i] = 0;
        end
      end
    end
    last_pair = {an, c};
    last_ok   = (d >= 0);
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc_n, act, exp);
    end
  endtask

  // One clock: drive, advance the model on the edge, compare just after it.
  task automatic cyc(input logic rst, input logic [3:0] an, input logic [6:0] c);
    reset = rst; an_in = an; c_in = c;
    @(posedge clk);
    model_edge(rst, an, c);
    #1;
    cyc_n++;
    if (word_valid === 1'b1) begin pulses++; pulse_at.push_back(cyc_n); end
    chk("word",       32'(word),       32'(e_word));
    chk("word_valid", 32'(word_valid), 32'(e_wv));
    chk("frame_err",  32'(frame_err),  32'(e_fe));
    chk("err_count",  32'(err_count),  32'(e_cnt));
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] c, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, an, c);
  endtask

  task automatic send_word(input logic [15:0] w, input int n);
    for (int d = 0; d < 4; d++) hold(an_of(d), seg_of(int'(w[d*4 +: 4])), n);
  endtask

  task automatic do_reset();
    cyc(1'b1, 4'hF, 7'h7F);
    pulses = 0;
    pulse_at.delete();
  endtask

  typedef struct {
    logic [6:0] c;
    logic [3:0] nib;
    bit         err;
  } vec_t;

  vec_t tbl[18];

  initial begin
    model_reset();
    // Glyph table: every legal pattern plus two illegal ones.
    for (int v = 0; v < 16; v++) begin
      tbl[v].c = seg_of(v); tbl[v].nib = 4'(v); tbl[v].err = 0;
    end
    tbl[16].c = 7'b1111111; tbl[16].nib = 4'h0; tbl[16].err = 1;
    tbl[17].c = 7'b0101010; tbl[17].nib = 4'h0; tbl[17].err = 1;

    // Reset state
    cyc(1'b1, 4'hF, 7'h7F);
    cyc(1'b1, 4'hF, 7'h7F);
    chk("rst_word", 32'(word), 32'h0);
    chk("rst_wv",   32'(word_valid), 32'h0);
    chk("rst_err",  32'(err_count), 32'h0);

    // Table-driven: same glyph on all four digits for exactly SETTLE cycles
    for (int i = 0; i < 18; i++) begin
      do_reset();
      for (int d = 0; d < 4; d++) hold(an_of(d), tbl[i].c, SETTLE);
      chk("tbl_word", 32'(word), 32'({4{tbl[i].nib}}));
      chk("tbl_ferr", 32'(frame_err), 32'(tbl[i].err));
      chk("tbl_wv",   32'(word_valid), 32'h1);
    end

    // Basic frame A5C3 at 6 cycles/digit
    do_reset();
    send_word(16'hA5C3, 6);
    chk("a5c3_word", 32'(word), 32'hA5C3);
    chk("a5c3_pulses", 32'(pulses), 32'd1);
    chk("a5c3_ferr", 32'(frame_err), 32'h0);

    // Short dwell (3 cycles) on digit 1 is never accepted
    do_reset();
    hold(an_of(0), seg_of(1), 4);
    hold(an_of(1), seg_of(2), 3);
    hold(an_of(2), seg_of(3), 4);
    hold(an_of(3), seg_of(4), 4);
    chk("short_nopulse", 32'(pulses), 32'd0);
    hold(an_of(1), seg_of(2), 4);
    chk("short_pulse", 32'(pulses), 32'd1);
    chk("short_word", 32'(word), 32'h4321);

    // Illegal glyph on digit 2
    do_reset();
    hold(an_of(0), seg_of(1), 5);
    hold(an_of(1), seg_of(2), 5);
    hold(an_of(2), 7'b1111111, 5);
    hold(an_of(3), seg_of(4), 5);
    chk("bad_word", 32'(word), 32'h4021);
    chk("bad_ferr", 32'(frame_err), 32'h1);
    hold(4'hF, 7'h7F, 2);
    chk("bad_cnt", 32'(err_count), 32'(ERRCNT_ON));

    // Invalid anode patterns between digits are ignored
    do_reset();
    hold(an_of(0), seg_of(7), 4);
    hold(4'b1111, seg_of(9), 5);
    hold(an_of(1), seg_of(8), 4);
    hold(4'b0011, seg_of(9), 5);
    hold(an_of(2), seg_of(9), 4);
    hold(4'b1111, 7'h7F, 5);
    hold(an_of(3), seg_of(6), 4);
    chk("gap_word", 32'(word), 32'h6987);
    chk("gap_pulses", 32'(pulses), 32'd1);

    // Reset mid-frame discards partial capture
    do_reset();
    send_word(16'h5555, 5);
    hold(an_of(0), seg_of(9), 5);
    hold(an_of(1), seg_of(9), 5);
    do_reset();
    chk("midrst_word", 32'(word), 32'h0);
    chk("midrst_ferr", 32'(frame_err), 32'h0);
    hold(an_of(2), seg_of(2), 5);
    hold(an_of(3), seg_of(1), 5);
    chk("midrst_nopulse", 32'(pulses), 32'd0);
    do_reset();
    send_word(16'h1234, 5);
    chk("1234_word", 32'(word), 32'h1234);
    chk("1234_pulses", 32'(pulses), 32'd1);

    // Continuous BEEF scan, 10 cycles/digit, two frames
    do_reset();
    send_word(16'hBEEF, 10);
    send_word(16'hBEEF, 10);
    hold(4'hF, 7'h7F, 2);
    chk("beef_pulses", 32'(pulses), 32'd2);
    if (pulse_at.size() == 2)
      chk("beef_spacing", 32'(pulse_at[1] - pulse_at[0]), 32'd40);
    chk("beef_word", 32'(word), 32'hBEEF);

    // Long dwell accepted once
    do_reset();
    hold(an_of(0), seg_of(13), 100);
    hold(an_of(1), seg_of(12), 4);
    hold(an_of(2), seg_of(11), 4);
    hold(an_of(3), seg_of(10), 4);
    chk("long_pulses", 32'(pulses), 32'd1);
    chk("long_word", 32'(word), 32'hABCD);

    // Randomized scan traffic against the model
    do_reset();
    for (int s = 0; s < 500; s++) begin
      logic [3:0] an;
      logic [6:0] c;
      int n;
      if ($urandom_range(0, 99) < 80) an = an_of($urandom_range(0, 3));
      else an = 4'($urandom);
      if ($urandom_range(0, 99) < 85) c = seg_of($urandom_range(0, 15));
      else c = 7'($urandom);
      n = $urandom_range(1, 7);
      if ($urandom_range(0, 99) < 2) cyc(1'b1, an, c);
      else hold(an, c, n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
